// File: rtl/anabellek_hakemi_pkg.sv
// Shared types and constants for the main-memory arbiter.
//   hakem_durum_t       : arbiter FSM states
//   istekci_t           : requester identity (instruction / data L1)
//   ANABELLEK_BASLANGIC : CPU-visible base of main memory
package anabellek_hakemi_pkg;

  typedef enum logic [1:0] {
    BOSTA = 2'd0,  // idle, evaluating requests
    ISTEK = 2'd1,  // request on memory port, waiting for grant
    BEKLE = 2'd2,  // granted, waiting for response
    YANIT = 2'd3   // completion pulse to the winner
  } hakem_durum_t;

  typedef enum logic {
    L1B = 1'b0,    // instruction cache controller
    L1V = 1'b1     // data cache controller
  } istekci_t;

  localparam logic [31:0] ANABELLEK_BASLANGIC = 32'h8000_0000;

endpackage

// File: rtl/anabellek_hakemi.sv
// Round-robin arbiter for the single main-memory port, shared between the
// L1 instruction cache (fills only) and the L1 data cache (fills and
// write-backs). One transaction is outstanding at a time; a watchdog
// completes hung transactions with zero data and raises a sticky error.
//
// Ports:
//   clk_i, rstn_i             clock, async active-low reset
//   l1b_istek_i/adres_i       instruction fill request and address
//   l1b_veri_o/hazir_o        returned line, one-cycle completion pulse
//   l1v_istek_i/yaz_i/adres_i data request, write-back flag, address
//   l1v_veri_i                write-back data
//   l1v_veri_o/hazir_o        returned line, one-cycle completion pulse
//   mem_req_o/gnt_i           memory request handshake
//   mem_addr_o/we_o/wdata_o/wstrb_o  translated request
//   mem_rdata_i/rvalid_i      memory response (reads and writes)
//   hata_o/hata_adres_o       sticky timeout flag, first timed-out address
module anabellek_hakemi
  import anabellek_hakemi_pkg::*;
#(
  parameter int unsigned                 ADRES_GENISLIGI    = 32,
  parameter int unsigned                 VERI_GENISLIGI     = 128,
  parameter logic [ADRES_GENISLIGI-1:0]  BELLEK_TABAN       = ADRES_GENISLIGI'(ANABELLEK_BASLANGIC),
  parameter int unsigned                 ZAMAN_ASIMI_CEVRIM = 1024
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,

  input  logic                          l1b_istek_i,
  input  logic [ADRES_GENISLIGI-1:0]    l1b_adres_i,
  output logic [VERI_GENISLIGI-1:0]     l1b_veri_o,
  output logic                          l1b_hazir_o,

  input  logic                          l1v_istek_i,
  input  logic                          l1v_yaz_i,
  input  logic [ADRES_GENISLIGI-1:0]    l1v_adres_i,
  input  logic [VERI_GENISLIGI-1:0]     l1v_veri_i,
  output logic [VERI_GENISLIGI-1:0]     l1v_veri_o,
  output logic                          l1v_hazir_o,

  output logic                          mem_req_o,
  input  logic                          mem_gnt_i,
  output logic [ADRES_GENISLIGI-1:0]    mem_addr_o,
  output logic                          mem_we_o,
  output logic [VERI_GENISLIGI-1:0]     mem_wdata_o,
  output logic [VERI_GENISLIGI/8-1:0]   mem_wstrb_o,
  input  logic [VERI_GENISLIGI-1:0]     mem_rdata_i,
  input  logic                          mem_rvalid_i,

  output logic                          hata_o,
  output logic [ADRES_GENISLIGI-1:0]    hata_adres_o
);

  localparam int unsigned            SAYAC_W   = $clog2(ZAMAN_ASIMI_CEVRIM);
  localparam logic [SAYAC_W-1:0]     SAYAC_SON = SAYAC_W'(ZAMAN_ASIMI_CEVRIM - 1);

  hakem_durum_t                  durum_q, durum_d;
  istekci_t                      son_kazanan_q, son_kazanan_d;
  istekci_t                      kazanan_q, kazanan_d;
  logic [ADRES_GENISLIGI-1:0]    adres_q, adres_d;       // untranslated, line aligned
  logic [SAYAC_W-1:0]            sayac_q, sayac_d;
  logic                          mem_req_q, mem_req_d;
  logic [ADRES_GENISLIGI-1:0]    mem_addr_q, mem_addr_d;
  logic                          mem_we_q, mem_we_d;
  logic [VERI_GENISLIGI/8-1:0]   mem_wstrb_q, mem_wstrb_d;
  logic [VERI_GENISLIGI-1:0]     mem_wdata_q, mem_wdata_d;
  logic [VERI_GENISLIGI-1:0]     l1b_veri_q, l1b_veri_d;
  logic                          l1b_hazir_q, l1b_hazir_d;
  logic [VERI_GENISLIGI-1:0]     l1v_veri_q, l1v_veri_d;
  logic                          l1v_hazir_q, l1v_hazir_d;
  logic                          hata_q, hata_d;
  logic [ADRES_GENISLIGI-1:0]    hata_adres_q, hata_adres_d;

  // Winner selection and the request it would launch from BOSTA.
  istekci_t                      secilen;
  logic [ADRES_GENISLIGI-1:0]    secilen_adres;
  logic                          secilen_yaz;

  // Completion of the current transaction (normal or watchdog).
  logic                          bitir;
  logic                          zaman_asimi;
  logic [VERI_GENISLIGI-1:0]     bitir_veri;

  always_comb begin
    secilen = L1B;
    if (l1b_istek_i && l1v_istek_i) begin
      // Tie: whoever did not win last time goes first.
      secilen = (son_kazanan_q == L1B) ? L1V : L1B;
    end else if (l1v_istek_i) begin
      secilen = L1V;
    end
    secilen_adres = (secilen == L1B) ? l1b_adres_i : l1v_adres_i;
    secilen_adres[3:0] = 4'h0;
    secilen_yaz = (secilen == L1V) && l1v_yaz_i;
  end

  always_comb begin
    durum_d       = durum_q;
    son_kazanan_d = son_kazanan_q;
    kazanan_d     = kazanan_q;
    adres_d       = adres_q;
    sayac_d       = sayac_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    mem_we_d      = mem_we_q;
    mem_wstrb_d   = mem_wstrb_q;
    mem_wdata_d   = mem_wdata_q;
    l1b_veri_d    = l1b_veri_q;
    l1v_veri_d    = l1v_veri_q;
    l1b_hazir_d   = 1'b0;
    l1v_hazir_d   = 1'b0;
    hata_d        = hata_q;
    hata_adres_d  = hata_adres_q;
    bitir         = 1'b0;
    zaman_asimi   = 1'b0;
    bitir_veri    = '0;

    unique case (durum_q)
      BOSTA: begin
        if (l1b_istek_i || l1v_istek_i) begin
          son_kazanan_d = secilen;
          kazanan_d     = secilen;
          adres_d       = secilen_adres;
          sayac_d       = '0;
          mem_req_d     = 1'b1;
          mem_addr_d    = secilen_adres - BELLEK_TABAN;
          mem_we_d      = secilen_yaz;
          mem_wstrb_d   = secilen_yaz ? '1 : '0;
          mem_wdata_d   = (secilen == L1V) ? l1v_veri_i : '0;
          durum_d       = ISTEK;
        end
      end

      ISTEK: begin
        sayac_d = sayac_q + 1'b1;
        if (mem_gnt_i) begin
          mem_req_d = 1'b0;
          if (mem_rvalid_i) begin
            bitir      = 1'b1;
            bitir_veri = mem_we_q ? '0 : mem_rdata_i;
          end else begin
            durum_d = BEKLE;
          end
        end else if (sayac_q == SAYAC_SON) begin
          mem_req_d   = 1'b0;
          zaman_asimi = 1'b1;
          bitir       = 1'b1;
        end
      end

      BEKLE: begin
        sayac_d = sayac_q + 1'b1;
        // A response arriving on the last watchdog cycle still counts.
        if (mem_rvalid_i) begin
          bitir      = 1'b1;
          bitir_veri = mem_we_q ? '0 : mem_rdata_i;
        end else if (sayac_q == SAYAC_SON) begin
          zaman_asimi = 1'b1;
          bitir       = 1'b1;
        end
      end

      YANIT: begin
        durum_d = BOSTA;
      end
    endcase

    if (bitir) begin
      durum_d = YANIT;
      if (kazanan_q == L1B) begin
        l1b_hazir_d = 1'b1;
        l1b_veri_d  = bitir_veri;
      end else begin
        l1v_hazir_d = 1'b1;
        l1v_veri_d  = bitir_veri;
      end
    end

    // Only the first timeout is recorded.
    if (zaman_asimi && !hata_q) begin
      hata_d       = 1'b1;
      hata_adres_d = adres_q;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      durum_q       <= BOSTA;
      son_kazanan_q <= L1V;   // so L1B wins the first tie
      kazanan_q     <= L1B;
      adres_q       <= '0;
      sayac_q       <= '0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      mem_we_q      <= 1'b0;
      mem_wstrb_q   <= '0;
      mem_wdata_q   <= '0;
      l1b_veri_q    <= '0;
      l1b_hazir_q   <= 1'b0;
      l1v_veri_q    <= '0;
      l1v_hazir_q   <= 1'b0;
      hata_q        <= 1'b0;
      hata_adres_q  <= '0;
    end else begin
      durum_q       <= durum_d;
      son_kazanan_q <= son_kazanan_d;
      kazanan_q     <= kazanan_d;
      adres_q       <= adres_d;
      sayac_q       <= sayac_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      mem_we_q      <= mem_we_d;
      mem_wstrb_q   <= mem_wstrb_d;
      mem_wdata_q   <= mem_wdata_d;
      l1b_veri_q    <= l1b_veri_d;
      l1b_hazir_q   <= l1b_hazir_d;
      l1v_veri_q    <= l1v_veri_d;
      l1v_hazir_q   <= l1v_hazir_d;
      hata_q        <= hata_d;
      hata_adres_q  <= hata_adres_d;
    end
  end

  assign l1b_veri_o   = l1b_veri_q;
  assign l1b_hazir_o  = l1b_hazir_q;
  assign l1v_veri_o   = l1v_veri_q;
  assign l1v_hazir_o  = l1v_hazir_q;
  assign mem_req_o    = mem_req_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_we_o     = mem_we_q;
  assign mem_wstrb_o  = mem_wstrb_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign hata_o       = hata_q;
  assign hata_adres_o = hata_adres_q;

endmodule

// File: tb/tb_anabellek_hakemi.sv
module tb_anabellek_hakemi;

  logic         clk_i = 1'b0;
  logic         rstn_i;
  logic         l1b_istek_i;
  logic [31:0]  l1b_adres_i;
  logic [127:0] l1b_veri_o;
  logic         l1b_hazir_o;
  logic         l1v_istek_i;
  logic         l1v_yaz_i;
  logic [31:0]  l1v_adres_i;
  logic [127:0] l1v_veri_i;
  logic [127:0] l1v_veri_o;
  logic         l1v_hazir_o;
  logic         mem_req_o;
  logic         mem_gnt_i;
  logic [31:0]  mem_addr_o;
  logic         mem_we_o;
  logic [127:0] mem_wdata_o;
  logic [15:0]  mem_wstrb_o;
  logic [127:0] mem_rdata_i;
  logic         mem_rvalid_i;
  logic         hata_o;
  logic [31:0]  hata_adres_o;

  always #5 clk_i = ~clk_i;

  anabellek_hakemi #(.ZAMAN_ASIMI_CEVRIM(8)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .l1b_istek_i(l1b_istek_i), .l1b_adres_i(l1b_adres_i),
    .l1b_veri_o(l1b_veri_o), .l1b_hazir_o(l1b_hazir_o),
    .l1v_istek_i(l1v_istek_i), .l1v_yaz_i(l1v_yaz_i),
    .l1v_adres_i(l1v_adres_i), .l1v_veri_i(l1v_veri_i),
    .l1v_veri_o(l1v_veri_o), .l1v_hazir_o(l1v_hazir_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
    .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
    .mem_rdata_i(mem_rdata_i), .mem_rvalid_i(mem_rvalid_i),
    .hata_o(hata_o), .hata_adres_o(hata_adres_o)
  );

  typedef struct {
    logic         b_ist;  logic [31:0] b_adr;
    logic         v_ist;  logic        v_yaz; logic [31:0] v_adr; logic [127:0] v_wd;
    logic         gnt;    logic        rv;    logic [127:0] rd;
    logic         e_req;  logic [31:0] e_addr; logic e_we; logic [127:0] e_wd;
    logic         e_bhz;  logic        e_vhz;
    logic [127:0] e_bv;   logic [127:0] e_vv;
  } vec_t;

  localparam logic [127:0] A5   = {16{8'hA5}};
  localparam logic [127:0] C3   = {16{8'hC3}};
  localparam logic [127:0] H5A  = {16{8'h5A}};
  localparam logic [127:0] D    = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] W    = 128'hFEED_FACE_0BAD_F00D_1357_9BDF_2468_ACE0;
  localparam logic [127:0] JUNK = {4{32'hDEAD_BEEF}};
  localparam logic [127:0] Z    = '0;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string ad, input logic [127:0] gercek, input logic [127:0] beklenen);
    n_cmp++;
    if (gercek !== beklenen) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", ad, gercek, beklenen);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic girisleri_sifirla;
    l1b_istek_i = 0; l1b_adres_i = '0;
    l1v_istek_i = 0; l1v_yaz_i = 0; l1v_adres_i = '0; l1v_veri_i = '0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
  endtask

  task automatic hepsi_sifir(input string p);
    chk({p, " req"},      128'(mem_req_o),    Z);
    chk({p, " addr"},     128'(mem_addr_o),   Z);
    chk({p, " we"},       128'(mem_we_o),     Z);
    chk({p, " wstrb"},    128'(mem_wstrb_o),  Z);
    chk({p, " wdata"},    mem_wdata_o,        Z);
    chk({p, " bhazir"},   128'(l1b_hazir_o),  Z);
    chk({p, " vhazir"},   128'(l1v_hazir_o),  Z);
    chk({p, " bveri"},    l1b_veri_o,         Z);
    chk({p, " vveri"},    l1v_veri_o,         Z);
    chk({p, " hata"},     128'(hata_o),       Z);
    chk({p, " hata_adr"}, 128'(hata_adres_o), Z);
  endtask

  function automatic vec_t mk(
    input logic b_ist, input logic [31:0] b_adr,
    input logic v_ist, input logic v_yaz, input logic [31:0] v_adr, input logic [127:0] v_wd,
    input logic gnt, input logic rv, input logic [127:0] rd,
    input logic e_req, input logic [31:0] e_addr, input logic e_we, input logic [127:0] e_wd,
    input logic e_bhz, input logic e_vhz, input logic [127:0] e_bv, input logic [127:0] e_vv);
    vec_t v;
    v.b_ist = b_ist; v.b_adr = b_adr;
    v.v_ist = v_ist; v.v_yaz = v_yaz; v.v_adr = v_adr; v.v_wd = v_wd;
    v.gnt = gnt; v.rv = rv; v.rd = rd;
    v.e_req = e_req; v.e_addr = e_addr; v.e_we = e_we; v.e_wd = e_wd;
    v.e_bhz = e_bhz; v.e_vhz = e_vhz; v.e_bv = e_bv; v.e_vv = e_vv;
    return v;
  endfunction

  vec_t vt[16];

  initial begin
    int ncomp;
    int cyc_c[3];
    int kim[3];
    int hz;

    // Each row: inputs for this cycle, expected registered outputs after the edge.
    //           b  b_adr          v  yz v_adr          v_wd gnt rv rd    req addr          we wd  bhz vhz bveri vveri
    vt[0]  = mk(1, 32'h8000_0040, 0, 0, 32'h0,         Z,   0, 0, Z,    1, 32'h0000_0040, 0, Z,  0, 0, Z,   Z);
    vt[1]  = mk(1, 32'h8000_0040, 0, 0, 32'h0,         Z,   1, 0, Z,    0, 32'h0,         0, Z,  0, 0, Z,   Z);
    vt[2]  = mk(1, 32'h8000_0040, 0, 0, 32'h0,         Z,   0, 0, Z,    0, 32'h0,         0, Z,  0, 0, Z,   Z);
    vt[3]  = mk(1, 32'h8000_0040, 0, 0, 32'h0,         Z,   0, 1, A5,   0, 32'h0,         0, Z,  1, 0, A5,  Z);
    vt[4]  = mk(0, 32'h0,         0, 0, 32'h0,         Z,   0, 0, Z,    0, 32'h0,         0, Z,  0, 0, A5,  Z);
    vt[5]  = mk(0, 32'h0,         1, 0, 32'h8000_0080, Z,   0, 0, Z,    1, 32'h0000_0080, 0, Z,  0, 0, A5,  Z);
    vt[6]  = mk(0, 32'h0,         1, 0, 32'h8000_0080, Z,   1, 1, C3,   0, 32'h0,         0, Z,  0, 1, A5,  C3);
    vt[7]  = mk(0, 32'h0,         0, 0, 32'h0,         Z,   0, 0, Z,    0, 32'h0,         0, Z,  0, 0, A5,  C3);
    vt[8]  = mk(0, 32'h0,         1, 1, 32'h8000_1238, D,   0, 0, Z,    1, 32'h0000_1230, 1, D,  0, 0, A5,  C3);
    vt[9]  = mk(0, 32'h0,         1, 1, 32'h8000_1238, D,   1, 0, Z,    0, 32'h0,         0, Z,  0, 0, A5,  C3);
    vt[10] = mk(0, 32'h0,         1, 1, 32'h8000_1238, D,   0, 1, JUNK, 0, 32'h0,         0, Z,  0, 1, A5,  Z);
    vt[11] = mk(0, 32'h0,         0, 0, 32'h0,         Z,   0, 0, Z,    0, 32'h0,         0, Z,  0, 0, A5,  Z);
    vt[12] = mk(1, 32'h0000_001C, 0, 0, 32'h0,         Z,   0, 0, Z,    1, 32'h8000_0010, 0, Z,  0, 0, A5,  Z);
    vt[13] = mk(1, 32'h0000_001C, 0, 0, 32'h0,         Z,   0, 1, JUNK, 1, 32'h8000_0010, 0, Z,  0, 0, A5,  Z);
    vt[14] = mk(1, 32'h0000_001C, 0, 0, 32'h0,         Z,   1, 1, H5A,  0, 32'h0,         0, Z,  1, 0, H5A, Z);
    vt[15] = mk(0, 32'h0,         0, 0, 32'h0,         Z,   0, 0, Z,    0, 32'h0,         0, Z,  0, 0, H5A, Z);

    girisleri_sifirla();
    rstn_i = 0;
    tick(); tick();
    // A stale response while reset is held must not leak through.
    mem_rvalid_i = 1; mem_rdata_i = JUNK;
    tick();
    rstn_i = 1;
    mem_rvalid_i = 0; mem_rdata_i = '0;
    hepsi_sifir("reset");

    for (int i = 0; i < 16; i++) begin
      l1b_istek_i = vt[i].b_ist; l1b_adres_i = vt[i].b_adr;
      l1v_istek_i = vt[i].v_ist; l1v_yaz_i = vt[i].v_yaz;
      l1v_adres_i = vt[i].v_adr; l1v_veri_i = vt[i].v_wd;
      mem_gnt_i = vt[i].gnt; mem_rvalid_i = vt[i].rv; mem_rdata_i = vt[i].rd;
      tick();
      chk($sformatf("v%0d req", i), 128'(mem_req_o), 128'(vt[i].e_req));
      if (vt[i].e_req) begin
        chk($sformatf("v%0d addr", i),  128'(mem_addr_o),  128'(vt[i].e_addr));
        chk($sformatf("v%0d we", i),    128'(mem_we_o),    128'(vt[i].e_we));
        chk($sformatf("v%0d wstrb", i), 128'(mem_wstrb_o), vt[i].e_we ? 128'hFFFF : Z);
        if (vt[i].e_we) chk($sformatf("v%0d wdata", i), mem_wdata_o, vt[i].e_wd);
      end
      chk($sformatf("v%0d bhazir", i), 128'(l1b_hazir_o), 128'(vt[i].e_bhz));
      chk($sformatf("v%0d vhazir", i), 128'(l1v_hazir_o), 128'(vt[i].e_vhz));
      chk($sformatf("v%0d bveri", i),  l1b_veri_o, vt[i].e_bv);
      chk($sformatf("v%0d vveri", i),  l1v_veri_o, vt[i].e_vv);
      chk($sformatf("v%0d hata", i),   128'(hata_o), Z);
    end

    // Simultaneous requests from reset, both held high; memory answers at once.
    girisleri_sifirla();
    rstn_i = 0; #2; rstn_i = 1;
    tick();
    l1b_istek_i = 1; l1b_adres_i = 32'h8000_0100;
    l1v_istek_i = 1; l1v_yaz_i = 0; l1v_adres_i = 32'h8000_0200;
    ncomp = 0;
    for (int c = 1; c <= 30 && ncomp < 3; c++) begin
      tick();
      if (l1b_hazir_o || l1v_hazir_o) begin
        kim[ncomp]   = l1v_hazir_o ? 1 : 0;
        cyc_c[ncomp] = c;
        ncomp++;
      end
      mem_gnt_i = mem_req_o; mem_rvalid_i = mem_req_o; mem_rdata_i = {4{mem_addr_o}};
    end
    l1b_istek_i = 0; l1v_istek_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;
    chk("rr completions", 128'(ncomp), 128'd3);
    if (ncomp == 3) begin
      chk("rr first L1B",  128'(kim[0]), 128'd0);
      chk("rr second L1V", 128'(kim[1]), 128'd1);
      chk("rr third L1B",  128'(kim[2]), 128'd0);
      chk("rr first cyc",  128'(cyc_c[0]), 128'd2);
      chk("rr gap1",       128'(cyc_c[1] - cyc_c[0]), 128'd3);
      chk("rr gap2",       128'(cyc_c[2] - cyc_c[1]), 128'd3);
    end
    chk("rr bveri", l1b_veri_o, {4{32'h0000_0100}});
    chk("rr vveri", l1v_veri_o, {4{32'h0000_0200}});
    tick();

    // Stalled grant: request held stable for five cycles without gnt.
    l1v_istek_i = 1; l1v_yaz_i = 1; l1v_adres_i = 32'h8000_2000; l1v_veri_i = W;
    tick();
    chk("stall req0", 128'(mem_req_o), 128'd1);
    for (int k = 0; k < 5; k++) begin
      mem_gnt_i = 0; mem_rvalid_i = (k == 2);
      tick();
      chk($sformatf("stall req%0d", k + 1),   128'(mem_req_o),   128'd1);
      chk($sformatf("stall addr%0d", k + 1),  128'(mem_addr_o),  128'h2000);
      chk($sformatf("stall wdata%0d", k + 1), mem_wdata_o,       W);
      chk($sformatf("stall hazir%0d", k + 1), 128'(l1v_hazir_o), Z);
    end
    mem_gnt_i = 1; mem_rvalid_i = 1; mem_rdata_i = JUNK;
    tick();
    chk("stall done hazir", 128'(l1v_hazir_o), 128'd1);
    chk("stall done veri",  l1v_veri_o, Z);
    l1v_istek_i = 0; l1v_yaz_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;
    tick();

    // Watchdog: granted but never answered.
    l1b_istek_i = 1; l1b_adres_i = 32'h8000_0300;
    tick();
    mem_gnt_i = 1;
    hz = 0;
    for (int c = 2; c <= 20; c++) begin
      tick();
      mem_gnt_i = 0;
      if (c == 8) chk("wd1 hata early", 128'(hata_o), Z);
      if (l1b_hazir_o) begin hz = c; break; end
    end
    chk("wd1 hazir cyc", 128'(hz), 128'd9);
    chk("wd1 bveri",     l1b_veri_o, Z);
    chk("wd1 hata",      128'(hata_o), 128'd1);
    chk("wd1 hata_adr",  128'(hata_adres_o), 128'h8000_0300);
    l1b_istek_i = 0;
    tick();

    // Second timeout, never granted: req must drop, error address must hold.
    l1v_istek_i = 1; l1v_yaz_i = 0; l1v_adres_i = 32'h8000_0400;
    tick();
    hz = 0;
    for (int c = 2; c <= 20; c++) begin
      tick();
      if (c == 8) chk("wd2 req held", 128'(mem_req_o), 128'd1);
      if (l1v_hazir_o) begin hz = c; break; end
    end
    chk("wd2 hazir cyc", 128'(hz), 128'd9);
    chk("wd2 req drop",  128'(mem_req_o), Z);
    chk("wd2 vveri",     l1v_veri_o, Z);
    chk("wd2 hata",      128'(hata_o), 128'd1);
    chk("wd2 hata_adr",  128'(hata_adres_o), 128'h8000_0300);
    l1v_istek_i = 0;
    tick();

    // Reset while in BEKLE, then a stale response.
    l1b_istek_i = 1; l1b_adres_i = 32'h8000_0500;
    tick();
    mem_gnt_i = 1;
    tick();
    mem_gnt_i = 0; l1b_istek_i = 0;
    #2 rstn_i = 0;
    #1 hepsi_sifir("midrst");
    @(posedge clk_i); #1;
    rstn_i = 1;
    mem_rvalid_i = 1; mem_rdata_i = JUNK;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk($sformatf("stale bhazir%0d", k), 128'(l1b_hazir_o), Z);
      chk($sformatf("stale vhazir%0d", k), 128'(l1v_hazir_o), Z);
      chk($sformatf("stale req%0d", k),    128'(mem_req_o),   Z);
      chk($sformatf("stale bveri%0d", k),  l1b_veri_o,        Z);
    end
    mem_rvalid_i = 0; mem_rdata_i = '0;
    // Idle state shows as a request launched on the very next edge.
    l1b_istek_i = 1; l1b_adres_i = 32'h8000_0600;
    tick();
    chk("post req",  128'(mem_req_o),  128'd1);
    chk("post addr", 128'(mem_addr_o), 128'h600);
    mem_gnt_i = 1; mem_rvalid_i = 1; mem_rdata_i = A5;
    tick();
    chk("post bhazir", 128'(l1b_hazir_o), 128'd1);
    chk("post bveri",  l1b_veri_o, A5);
    girisleri_sifirla();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
